load_ext_reg: RTL
=================

Name: load_ext_reg

Overview:
- Registered load-data extractor/extender for the multicycle datapath; acts as the memory data register stage between data memory and the register-file write mux.
- Each cycle it:
  - selects a byte, halfword, word or doubleword lane from the memory read word by address offset (little-endian);
  - sign- or zero-extends that lane to the datapath width;
  - flags misaligned or oversized accesses.
- It also supports hold/stall and keeps a saturating misalignment-error counter for debug.

Parameters:
- DWIDTH, 32, memory read-data width; multiple of 8, power of 2, range 16..64.
- OWIDTH, 32, output width; must be >= DWIDTH.
- CNTW, 8, width of the saturating error counter.
- OFFW (localparam), clog2(DWIDTH/8), offset width; minimum 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- i_valid  input  1  load request present this cycle.
- i_data  input  DWIDTH  memory read word.
- i_offset  input  OFFW  byte offset of the access within i_data (address low bits).
- i_size  input  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
- i_sign  input  1  1 = sign-extend, 0 = zero-extend.
- i_hold  input  1  stall; freeze all registers.
- o_data  output  OWIDTH  extracted, extended load result (registered).
- o_valid  output  1  o_data/o_err correspond to a captured request.
- o_err  output  1  captured request was misaligned or oversized.
- o_err_cnt  output  CNTW  saturating count of erroneous captured requests.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: o_data = 0, o_valid = 0, o_err = 0, o_err_cnt = 0.
- Priority each edge: rst > i_hold > normal update.
  - rst mid-operation discards any in-flight result.
  - rst during i_hold still resets.
- i_hold = 1: all outputs, including o_err_cnt, keep their values; inputs are ignored.
- Normal update (i_hold = 0):
  - o_valid <= i_valid.
  - If i_valid = 0: o_data and o_err hold their previous values; o_err_cnt unchanged.
- Latency: exactly 1 cycle from an accepted request to the result. No back-pressure; one request can be accepted per cycle.
- Lane selection:
  - nbytes = 2^i_size.
  - Lane = i_data[i_offset*8 +: nbytes*8].
- Error conditions (captured request with i_valid = 1):
  - oversized: nbytes*8 > DWIDTH (e.g. i_size = 3 with DWIDTH = 32);
  - misaligned: i_offset not a multiple of nbytes (i_offset mod nbytes != 0).
- On error: o_data <= 0, o_err <= 1, o_err_cnt <= o_err_cnt + 1, saturating at 2^CNTW - 1 with no wrap.
- No error: o_err <= 0.
  - i_sign = 1: o_data <= lane with its MSB replicated to OWIDTH.
  - i_sign = 0: o_data <= lane zero-padded to OWIDTH.
- Full-width access (nbytes*8 = DWIDTH, offset 0): i_data is passed through, extended to OWIDTH when OWIDTH > DWIDTH. Extension depends on i_sign.
- Offset bits above the access alignment are used directly for lane selection; there is no wrap-around within i_data.
- Purely synchronous; no combinational path from inputs to outputs.

Test Plan (DWIDTH = 32, OWIDTH = 32, CNTW = 8, i_data = 0x8081_F2F3 unless stated):
- Reset check: rst = 1 for 2 cycles, then release -> o_data = 0, o_valid = 0, o_err = 0, o_err_cnt = 0.
- Byte loads:
  - i_size = 0, i_offset = 0, i_sign = 1 -> next cycle o_data = 0xFFFF_FFF3, o_valid = 1, o_err = 0.
  - i_offset = 3, i_sign = 0 -> o_data = 0x0000_0080.
- Half loads:
  - i_size = 1, i_offset = 2, i_sign = 1 -> o_data = 0xFFFF_8081.
  - i_offset = 0, i_sign = 0 -> o_data = 0x0000_F2F3.
- Word load: i_size = 2, i_offset = 0 -> o_data = 0x8081_F2F3 for either i_sign.
- Errors:
  - i_size = 1, i_offset = 1 -> o_data = 0, o_err = 1, o_err_cnt = 1.
  - i_size = 3 -> o_err = 1, o_err_cnt = 2.
  - Back-to-back 300 misaligned requests -> o_err_cnt saturates at 255.
- Hold and reset interaction:
  - i_hold = 1 with a new valid request -> outputs unchanged for the full hold duration.
  - Release hold -> request applied on the next edge.
  - rst asserted while i_hold = 1 and o_err_cnt = 5 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/load_ext_reg.sv
// Memory data register for the multicycle datapath: picks a byte/half/word/dword
// lane out of the read word, sign- or zero-extends it, and flags bad accesses.
module load_ext_reg #(
  parameter int DWIDTH = 32,
  parameter int OWIDTH = 32,
  parameter int CNTW   = 8,
  localparam int OFFW  = (DWIDTH / 8 > 1) ? $clog2(DWIDTH / 8) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_data,
  input  logic [OFFW-1:0]   i_offset,
  input  logic [1:0]        i_size,
  input  logic              i_sign,
  input  logic              i_hold,
  output logic [OWIDTH-1:0] o_data,
  output logic              o_valid,
  output logic              o_err,
  output logic [CNTW-1:0]   o_err_cnt
);

  if (DWIDTH < 16 || DWIDTH > 64 || (DWIDTH & (DWIDTH - 1)) != 0) begin : g_bad_dwidth
    $error("load_ext_reg: DWIDTH must be a power of 2 in 16..64");
  end
  if (OWIDTH < DWIDTH) begin : g_bad_owidth
    $error("load_ext_reg: OWIDTH must be >= DWIDTH");
  end

  logic [OWIDTH-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              err_q,   err_d;
  logic [CNTW-1:0]   cnt_q,   cnt_d;

  // Lane extraction: shift the addressed byte down to bit 0, then mask/extend
  // by the access width. Oversized or misaligned requests never reach the
  // extender result, so lane_bits <= DWIDTH wherever ext_lane is used.
  logic [OWIDTH-1:0] shifted;
  logic [OWIDTH-1:0] ext_lane;
  logic              lane_msb;
  logic              oversized;
  logic              misaligned;
  int                lane_bits;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    data_d     = data_q;
    valid_d    = valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    lane_msb   = 1'b0;
    ext_lane   = '0;

    lane_bits  = 8 << i_size;
    shifted    = OWIDTH'(i_data) >> {i_offset, 3'b000};
    oversized  = lane_bits > DWIDTH;
    misaligned = (int'(i_offset) & ((1 << i_size) - 1)) != 0;

    for (int i = 0; i < DWIDTH; i++) begin
      if (i == lane_bits - 1) lane_msb = shifted[i];
    end

    for (int i = 0; i < OWIDTH; i++) begin
      ext_lane[i] = (i < lane_bits) ? shifted[i] : (i_sign & lane_msb);
    end

    if (!i_hold) begin
      valid_d = i_valid;
      if (i_valid) begin
        if (oversized || misaligned) begin
          data_d = '0;
          err_d  = 1'b1;
          if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + CNTW'(1);
        end else begin
          data_d = ext_lane;
          err_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_err     = err_q;
  assign o_err_cnt = cnt_q;

endmodule
